// File: rtl/reaction_pkg.sv
// rtl/reaction_pkg.sv - shared types and constants for the reaction timer
package reaction_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RUN,
    ST_DONE,
    ST_FOUL
  } state_t;

  localparam logic [3:0] BCD_NINE = 4'd9;

  // Fibonacci taps 16,14,13,11 as a mask over lfsr[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d == BCD_NINE) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/bcd4_counter.sv
// rtl/bcd4_counter.sv - four-digit BCD ripple counter saturating at 9999
module bcd4_counter
  import reaction_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_set9,
  input  logic       i_inc,
  output logic [3:0] o_d0,
  output logic [3:0] o_d1,
  output logic [3:0] o_d2,
  output logic [3:0] o_d3,
  output logic       o_sat
);

  logic [3:0][3:0] r_d;
  logic [3:0]      w_nine;

  // per-digit "is nine" flags drive both the ripple carry and saturation
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_nine[i] = (r_d[i] == BCD_NINE);
    end
  end

  assign o_sat = &w_nine;
  assign o_d0  = r_d[0];
  assign o_d1  = r_d[1];
  assign o_d2  = r_d[2];
  assign o_d3  = r_d[3];

  // clear beats force-to-nines beats increment; increments stop at 9999
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_d <= '0;
    end else if (i_clr) begin
      r_d <= '0;
    end else if (i_set9) begin
      r_d <= {4{BCD_NINE}};
    end else if (i_inc && !o_sat) begin
      r_d[0] <= bcd_inc(r_d[0]);
      if (w_nine[0])    r_d[1] <= bcd_inc(r_d[1]);
      if (&w_nine[1:0]) r_d[2] <= bcd_inc(r_d[2]);
      if (&w_nine[2:0]) r_d[3] <= bcd_inc(r_d[3]);
    end
  end

endmodule

// File: rtl/reaction_timer.sv
// rtl/reaction_timer.sv - reaction-time trial controller feeding HighScore
module reaction_timer
  import reaction_pkg::*;
#(
  parameter int          DELAY_MIN_MS    = 1000,
  parameter int          DELAY_SPAN_BITS = 12,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick_ms,
  input  logic       i_start_btn,
  input  logic       i_stop_btn,
  output logic [3:0] o_digit0,
  output logic [3:0] o_digit1,
  output logic [3:0] o_digit2,
  output logic [3:0] o_digit3,
  output logic       o_idle,
  output logic       o_go_led,
  output logic       o_foul
);

  localparam int WAIT_W = $clog2(DELAY_MIN_MS + 2**DELAY_SPAN_BITS);

  state_t            r_state;
  logic [15:0]       r_lfsr;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_idle;
  logic              r_go_led;
  logic              r_foul;

  logic [WAIT_W-1:0] w_wait_load;
  logic              w_arm;
  logic              w_set9;
  logic              w_inc;
  logic              w_sat;

  assign w_wait_load = WAIT_W'(DELAY_MIN_MS) + WAIT_W'(r_lfsr[DELAY_SPAN_BITS-1:0]);

  // a new trial may only be armed from a resting state
  assign w_arm  = i_start_btn && (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_FOUL);
  assign w_set9 = (r_state == ST_WAIT) && i_stop_btn;
  // a stop in the same cycle as a tick wins, so the latched time is the pre-stop count
  assign w_inc  = (r_state == ST_RUN) && i_tick_ms && !i_stop_btn && !w_sat;

  bcd4_counter u_count (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_arm),
    .i_set9 (w_set9),
    .i_inc  (w_inc),
    .o_d0   (o_digit0),
    .o_d1   (o_digit1),
    .o_d2   (o_digit2),
    .o_d3   (o_digit3),
    .o_sat  (w_sat)
  );

  // free-running hold-off randomiser, advances every clock regardless of state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_lfsr <= LFSR_SEED;
    else       r_lfsr <= lfsr_next(r_lfsr);
  end

  // trial sequencer: hold-off countdown, run, result/foul with registered flags
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_idle     <= 1'b0;
      r_go_led   <= 1'b0;
      r_foul     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_FOUL: begin
          if (i_start_btn) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= w_wait_load;
            r_idle     <= 1'b0;
            r_foul     <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (i_stop_btn) begin
            r_state <= ST_FOUL;
            r_foul  <= 1'b1;
          end else if (i_tick_ms) begin
            if (r_wait_cnt <= WAIT_W'(1)) begin
              r_state  <= ST_RUN;
              r_go_led <= 1'b1;
            end else begin
              r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
            end
          end
        end
        ST_RUN: begin
          // a saturated count is a timeout even if stop arrives now
          if (w_sat) begin
            r_state  <= ST_FOUL;
            r_foul   <= 1'b1;
            r_go_led <= 1'b0;
          end else if (i_stop_btn) begin
            r_state  <= ST_DONE;
            r_idle   <= 1'b1;
            r_go_led <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_idle   <= 1'b0;
          r_go_led <= 1'b0;
          r_foul   <= 1'b0;
        end
      endcase
    end
  end

  assign o_idle   = r_idle;
  assign o_go_led = r_go_led;
  assign o_foul   = r_foul;

endmodule

// File: tb/tb_reaction_timer.sv
// tb/tb_reaction_timer.sv - self-checking bench for reaction_timer
module tb_reaction_timer;

  logic clk = 1'b0;
  logic rst;
  logic tick;
  logic start;
  logic stop;
  logic [3:0] d0, d1, d2, d3;
  logic idle, go, foul;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reaction_timer #(
    .DELAY_MIN_MS    (2),
    .DELAY_SPAN_BITS (2),
    .LFSR_SEED       (16'h0001)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_tick_ms   (tick),
    .i_start_btn (start),
    .i_stop_btn  (stop),
    .o_digit0    (d0),
    .o_digit1    (d1),
    .o_digit2    (d2),
    .o_digit3    (d3),
    .o_idle      (idle),
    .o_go_led    (go),
    .o_foul      (foul)
  );

  logic [15:0] obs_digits;
  logic [18:0] obs;
  assign obs_digits = {d3, d2, d1, d0};
  assign obs        = {d3, d2, d1, d0, idle, go, foul};

  // decimal millisecond count to the four expected BCD digits
  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // one clock: drive at the falling edge, return at the next falling edge
  task automatic step(input logic s, input logic p, input logic t);
    start = s;
    stop  = p;
    tick  = t;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    tick  = 1'b0;
  endtask

  // tick every cycle until GO lights; hold-off must be 2..5 ticks
  task automatic wait_go(input logic with_start, output int nt);
    nt = 0;
    while (go !== 1'b1 && nt < 12) begin
      checks++;
      if (foul !== 1'b0 || idle !== 1'b0 || obs_digits !== 16'h0000) begin
        errors++;
        $display("FAIL wait_flags digits=%h idle=%b foul=%b required 0000/0/0", obs_digits, idle, foul);
      end
      step(with_start ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, 1'b1);
      nt++;
    end
    checks++;
    if (go !== 1'b1 || nt < 2 || nt > 5) begin
      errors++;
      $display("FAIL holdoff ticks=%0d go=%b required 2..5 ticks and go=1", nt, go);
    end
  endtask

  task automatic test_reset();
    int nt;
    int n;
    rst = 1'b1; start = 1'b0; stop = 1'b0; tick = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== 19'h0) begin errors++; $display("FAIL reset_state obs=%h required %h", obs, 19'h0); end
    rst = 1'b0;
    @(negedge clk);
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if (obs !== 19'h0) begin errors++; $display("FAIL idle_stop_ignored obs=%h required %h", obs, 19'h0); end
    step(1'b1, 1'b0, 1'b0);
    wait_go(1'b0, nt);
    n = $urandom_range(5, 60);
    repeat (n) step(1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== {to_bcd(n), 3'b010}) begin
      errors++; $display("FAIL pre_reset_run obs=%h required %h", obs, {to_bcd(n), 3'b010});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== 19'h0) begin errors++; $display("FAIL async_reset obs=%h required %h", obs, 19'h0); end
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== 19'h0) begin errors++; $display("FAIL post_reset_idle obs=%h required %h", obs, 19'h0); end
  endtask

  task automatic test_normal();
    int nt;
    step(1'b1, 1'b0, 1'b0);
    wait_go(1'b0, nt);
    repeat (123) step(1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== {to_bcd(123), 3'b010}) begin
      errors++; $display("FAIL run_123 obs=%h required %h", obs, {to_bcd(123), 3'b010});
    end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== {16'h0123, 3'b100}) begin
      errors++; $display("FAIL done_123 obs=%h required %h", obs, {16'h0123, 3'b100});
    end
    repeat (3) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if (obs !== {16'h0123, 3'b100}) begin
      errors++; $display("FAIL done_frozen obs=%h required %h", obs, {16'h0123, 3'b100});
    end
  endtask

  task automatic test_foul_wait();
    int go_seen;
    step(1'b1, 1'b0, 1'b0);
    if ($urandom_range(0, 1) == 1) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if (obs !== {16'h9999, 3'b001}) begin
      errors++; $display("FAIL wait_stop_foul obs=%h required %h", obs, {16'h9999, 3'b001});
    end
    go_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, (i == 3), 1'b1);
      if (go === 1'b1) go_seen++;
    end
    checks++;
    if (go_seen != 0 || obs !== {16'h9999, 3'b001}) begin
      errors++; $display("FAIL foul_hold obs=%h go_cycles=%0d required %h and 0", obs, go_seen, {16'h9999, 3'b001});
    end
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== 19'h0) begin errors++; $display("FAIL foul_restart obs=%h required %h", obs, 19'h0); end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== {16'h9999, 3'b001}) begin
      errors++; $display("FAIL second_foul obs=%h required %h", obs, {16'h9999, 3'b001});
    end
  endtask

  task automatic test_stop_tick();
    int nt;
    step(1'b1, 1'b0, 1'b0);
    wait_go(1'b0, nt);
    repeat (9) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if (obs !== {16'h0009, 3'b100}) begin
      errors++; $display("FAIL stop_tick_same obs=%h required %h", obs, {16'h0009, 3'b100});
    end
  endtask

  task automatic test_back_to_back();
    int nt;
    int cnt;
    step(1'b1, 1'b0, 1'b0);
    wait_go(1'b1, nt);
    cnt = 0;
    while (cnt < 250) begin
      if ($urandom_range(0, 4) == 0) begin
        step(1'b1, 1'b0, 1'b0);
      end else begin
        step(1'($urandom_range(0, 1)), 1'b0, 1'b1);
        cnt++;
      end
    end
    checks++;
    if (obs !== {16'h0250, 3'b010}) begin
      errors++; $display("FAIL run_250_with_starts obs=%h required %h", obs, {16'h0250, 3'b010});
    end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== {16'h0250, 3'b100}) begin
      errors++; $display("FAIL done_250 obs=%h required %h", obs, {16'h0250, 3'b100});
    end
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== 19'h0) begin errors++; $display("FAIL restart_from_done obs=%h required %h", obs, 19'h0); end
    wait_go(1'b0, nt);
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== {16'h0000, 3'b100}) begin
      errors++; $display("FAIL done_zero obs=%h required %h", obs, {16'h0000, 3'b100});
    end
  endtask

  task automatic test_random();
    int nt;
    int cnt;
    int len;
    logic t;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      checks++;
      if (obs !== 19'h0) begin errors++; $display("FAIL rand_restart[%0d] obs=%h required %h", k, obs, 19'h0); end
      wait_go(1'b0, nt);
      cnt = 0;
      len = $urandom_range(0, 300);
      for (int c = 0; c < len; c++) begin
        t = 1'($urandom_range(0, 1));
        step(1'b0, 1'b0, t);
        if (t) cnt++;
      end
      checks++;
      if (obs !== {to_bcd(cnt), 3'b010}) begin
        errors++; $display("FAIL rand_run[%0d] obs=%h required %h", k, obs, {to_bcd(cnt), 3'b010});
      end
      step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
      step(1'b0, 1'b1, 1'b1);
      checks++;
      if (obs !== {to_bcd(cnt), 3'b100}) begin
        errors++; $display("FAIL rand_done[%0d] obs=%h required %h", k, obs, {to_bcd(cnt), 3'b100});
      end
    end
  endtask

  task automatic test_timeout();
    int nt;
    step(1'b1, 1'b0, 1'b0);
    wait_go(1'b0, nt);
    repeat (9998) step(1'b0, 1'b0, 1'b1);
    checks++;
    if (obs !== {16'h9998, 3'b010}) begin
      errors++; $display("FAIL pre_sat obs=%h required %h", obs, {16'h9998, 3'b010});
    end
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (obs_digits !== 16'h9999 || idle !== 1'b0) begin
      errors++; $display("FAIL reach_9999 digits=%h idle=%b required 9999 and 0", obs_digits, idle);
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== {16'h9999, 3'b001}) begin
      errors++; $display("FAIL timeout_foul obs=%h required %h", obs, {16'h9999, 3'b001});
    end
    repeat (5) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if (obs !== {16'h9999, 3'b001}) begin
      errors++; $display("FAIL sat_hold obs=%h required %h", obs, {16'h9999, 3'b001});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_normal();
    test_foul_wait();
    test_stop_tick();
    test_back_to_back();
    test_random();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
